// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared IO offsets, timer control bits and target-select type for mmio_bridge
package mmio_pkg;

    localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FF00;

    localparam logic [7:0] OFS_LED    = 8'h00;
    localparam logic [7:0] OFS_SW     = 8'h04;
    localparam logic [7:0] OFS_TCTRL  = 8'h08;
    localparam logic [7:0] OFS_TLOAD  = 8'h0C;
    localparam logic [7:0] OFS_TCOUNT = 8'h10;
    localparam logic [7:0] OFS_TSTAT  = 8'h14;
    localparam logic [7:0] OFS_FAULT  = 8'h18;

    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_AUTO = 1;
    localparam int TCTRL_IE   = 2;

    typedef enum logic [1:0] {
        SEL_RAM,
        SEL_IO,
        SEL_NONE
    } sel_t;

endpackage

// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - prescaled down-counting timer with sticky expiry flag and interrupt
module mmio_timer
    import mmio_pkg::*;
#(
    parameter int PRESC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic [7:0]  ofs,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    logic [PW-1:0] presc;
    logic [2:0]    ctrl;
    logic [31:0]   tload;
    logic [31:0]   tcount;
    logic          exp_flag;
    logic          wr_ctrl, wr_load, wr_stat, tick, expire;

    assign wr_ctrl = wr && (ofs == OFS_TCTRL);
    assign wr_load = wr && (ofs == OFS_TLOAD);
    assign wr_stat = wr && (ofs == OFS_TSTAT);
    assign tick    = ctrl[TCTRL_EN] && (presc == PRESC_LAST);
    assign expire  = tick && (tcount == 32'd0);
    assign irq     = exp_flag && ctrl[TCTRL_IE];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            ctrl     <= 3'd0;
            tload    <= 32'd0;
            tcount   <= 32'd0;
            exp_flag <= 1'b0;
        end else begin
            if (!ctrl[TCTRL_EN] || tick || wr_load)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            // A control write overrides the one-shot self-disable.
            if (wr_ctrl)
                ctrl <= wd[2:0];
            else if (expire && !ctrl[TCTRL_AUTO])
                ctrl[TCTRL_EN] <= 1'b0;

            if (wr_load) begin
                tload  <= wd;
                tcount <= wd;
            end else if (tick) begin
                if (tcount != 32'd0)
                    tcount <= tcount - 32'd1;
                else if (ctrl[TCTRL_AUTO])
                    tcount <= tload;
            end

            if (expire)
                exp_flag <= 1'b1;
            else if (wr_stat && wd[0])
                exp_flag <= 1'b0;
        end
    end

    always_comb begin
        rd  = 32'd0;
        hit = 1'b1;
        case (ofs)
            OFS_TCTRL:  rd = {29'd0, ctrl};
            OFS_TLOAD:  rd = tload;
            OFS_TCOUNT: rd = tcount;
            OFS_TSTAT:  rd = {31'd0, exp_flag};
            default:    hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU memory-port decoder to RAM, LED/switch/timer registers; MMIO_BUS_FAULT_EN adds fault capture
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int          RAM_AW  = 12,
    parameter int          PRESC   = 4,
    parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       adr,
    input  logic [31:0]       writedata,
    input  logic              MemWrite,
    output logic [31:0]       readdata,
    output logic [RAM_AW-1:0] ram_adr,
    output logic              ram_we,
    output logic [31:0]       ram_wd,
    input  logic [31:0]       ram_rd,
    output logic [15:0]       led,
    input  logic [15:0]       sw,
    output logic              irq,
    output logic              bus_fault
);

    sel_t        sel;
    logic [7:0]  ofs;
    logic        io_we, io_valid;
    logic [31:0] io_rd, tmr_rd;
    logic        tmr_hit;
    logic [15:0] sw_meta, sw_sync;
`ifdef MMIO_BUS_FAULT_EN
    logic        fault_flag, fault_ev, fault_clr;
    logic [31:0] fault_adr;
`endif

    assign ofs = {adr[7:2], 2'b00};

    always_comb begin
        if ((adr >> (RAM_AW + 2)) == 32'd0)
            sel = SEL_RAM;
        else if (adr[31:8] == IO_BASE[31:8])
            sel = SEL_IO;
        else
            sel = SEL_NONE;
    end

    assign ram_adr = adr[RAM_AW+1:2];
    assign ram_we  = MemWrite && (sel == SEL_RAM);
    assign ram_wd  = writedata;
    assign io_we   = MemWrite && (sel == SEL_IO);

    mmio_timer #(.PRESC(PRESC)) u_timer (
        .clk (clk),
        .rst (rst),
        .wr  (io_we),
        .ofs (ofs),
        .wd  (writedata),
        .rd  (tmr_rd),
        .hit (tmr_hit),
        .irq (irq)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led     <= 16'd0;
            sw_meta <= 16'd0;
            sw_sync <= 16'd0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            if (io_we && (ofs == OFS_LED))
                led <= writedata[15:0];
        end
    end

    always_comb begin
        io_rd    = tmr_rd;
        io_valid = tmr_hit;
        case (ofs)
            OFS_LED: begin io_rd = {16'd0, led};     io_valid = 1'b1; end
            OFS_SW:  begin io_rd = {16'd0, sw_sync}; io_valid = 1'b1; end
`ifdef MMIO_BUS_FAULT_EN
            OFS_FAULT: begin io_rd = fault_adr;      io_valid = 1'b1; end
`endif
            default: ;
        endcase
    end

    always_comb begin
        readdata = 32'd0;
        case (sel)
            SEL_RAM: readdata = ram_rd;
            SEL_IO:  readdata = io_valid ? io_rd : 32'd0;
            default: ;
        endcase
    end

`ifdef MMIO_BUS_FAULT_EN
    // Every cycle presents an access, so a sustained bad address keeps re-asserting the event.
    assign fault_ev  = (sel == SEL_NONE) || ((sel == SEL_IO) && !io_valid);
    assign fault_clr = io_we && (ofs == OFS_FAULT);
    assign bus_fault = fault_flag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_flag <= 1'b0;
            fault_adr  <= 32'd0;
        end else if (fault_ev && (!fault_flag || fault_clr)) begin
            fault_flag <= 1'b1;
            fault_adr  <= adr;
        end else if (fault_clr) begin
            fault_flag <= 1'b0;
            fault_adr  <= 32'd0;
        end
    end
`else
    assign bus_fault = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - directed and randomized checks of mmio_bridge against a behavioural model
module tb_mmio_bridge;

    localparam int          RAM_AW    = 12;
    localparam int          PRESC     = 4;
    localparam logic [31:0] RAM_BYTES = 32'(4 << RAM_AW);

    logic              clk;
    logic              rst;
    logic [31:0]       adr;
    logic [31:0]       writedata;
    logic              MemWrite;
    logic [31:0]       readdata;
    logic [RAM_AW-1:0] ram_adr;
    logic              ram_we;
    logic [31:0]       ram_wd;
    logic [31:0]       ram_rd;
    logic [15:0]       led;
    logic [15:0]       sw;
    logic              irq;
    logic              bus_fault;

    mmio_bridge #(.RAM_AW(RAM_AW), .PRESC(PRESC)) dut (
        .clk       (clk),
        .rst       (rst),
        .adr       (adr),
        .writedata (writedata),
        .MemWrite  (MemWrite),
        .readdata  (readdata),
        .ram_adr   (ram_adr),
        .ram_we    (ram_we),
        .ram_wd    (ram_wd),
        .ram_rd    (ram_rd),
        .led       (led),
        .sw        (sw),
        .irq       (irq),
        .bus_fault (bus_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural state of the peripheral window
    logic [15:0] m_led, m_sw1, m_sw2;
    logic        m_en, m_auto, m_ie, m_exp, m_bf;
    logic [31:0] m_tload, m_tcount, m_fadr;
    int          m_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_led = 0; m_sw1 = 0; m_sw2 = 0;
        m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_bf = 0;
        m_tload = 0; m_tcount = 0; m_fadr = 0; m_phase = 0;
    endtask

    function automatic logic is_io(input logic [31:0] a);
        return (a >= RAM_BYTES) && (a[31:8] == 24'hFFFFFF);
    endfunction

    function automatic logic known_ofs(input logic [7:0] o);
`ifdef MMIO_BUS_FAULT_EN
        return o <= 8'h18;
`else
        return o <= 8'h14;
`endif
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [31:0] r);
        logic [7:0] o;
        o = a[7:0] & 8'hFC;
        if (a < RAM_BYTES) return r;
        if (!is_io(a) || !known_ofs(o)) return 32'd0;
        case (o)
            8'h00: return {16'd0, m_led};
            8'h04: return {16'd0, m_sw2};
            8'h08: return {29'd0, m_ie, m_auto, m_en};
            8'h0C: return m_tload;
            8'h10: return m_tcount;
            8'h14: return {31'd0, m_exp};
            8'h18: return m_fadr;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic [15:0] s);
        logic [7:0]  o;
        logic        io, iow, tick, expire, ev, clr;
        logic        n_en, n_auto, n_ie, n_exp;
        logic [31:0] n_tcount, n_tload;
        int          n_phase;
        o   = a[7:0] & 8'hFC;
        io  = is_io(a);
        iow = w && io;
        tick   = m_en && (m_phase == PRESC - 1);
        expire = tick && (m_tcount == 0);
        n_phase = (!m_en || tick || (iow && o == 8'h0C)) ? 0 : m_phase + 1;
        n_en = m_en; n_auto = m_auto; n_ie = m_ie;
        n_tcount = m_tcount; n_tload = m_tload;
        if (tick) begin
            if (m_tcount != 0) n_tcount = m_tcount - 1;
            else if (m_auto)   n_tcount = m_tload;
            else               n_en = 1'b0;
        end
        if (iow) begin
            case (o)
                8'h00: m_led = d[15:0];
                8'h08: {n_ie, n_auto, n_en} = d[2:0];
                8'h0C: begin n_tload = d; n_tcount = d; end
                default: ;
            endcase
        end
        n_exp = expire ? 1'b1 : ((iow && o == 8'h14 && d[0]) ? 1'b0 : m_exp);
`ifdef MMIO_BUS_FAULT_EN
        ev  = (a >= RAM_BYTES && !io) || (io && !known_ofs(o));
        clr = iow && o == 8'h18;
        if (ev && (!m_bf || clr)) begin m_bf = 1'b1; m_fadr = a; end
        else if (clr)             begin m_bf = 1'b0; m_fadr = 32'd0; end
`else
        ev = 1'b0; clr = 1'b0;
`endif
        m_en = n_en; m_auto = n_auto; m_ie = n_ie; m_exp = n_exp;
        m_tcount = n_tcount; m_tload = n_tload; m_phase = n_phase;
        m_sw2 = m_sw1; m_sw1 = s;
    endtask

    // Drive one access, compare combinational outputs, then commit it on the next edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input logic [15:0] s, input logic [31:0] r);
        adr = a; writedata = d; MemWrite = w; sw = s; ram_rd = r;
        #1;
        check("readdata", readdata, exp_rd(a, r));
        check("ram_we", ram_we, w && (a < RAM_BYTES));
        check("ram_adr", 32'(ram_adr), 32'(a[RAM_AW+1:2]));
        check("ram_wd", ram_wd, d);
        check("led", led, m_led);
        check("irq", irq, m_exp && m_ie);
        check("bus_fault", bus_fault, m_bf);
        @(posedge clk);
        model_update(a, d, w, s);
        #1;
    endtask

    logic [7:0]  offs [0:9];
    logic [15:0] cur_sw;

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h40, 8'hFC};
        rst = 1'b0; adr = 32'hFFFF_FF10; writedata = 0; MemWrite = 0; sw = 0; ram_rd = 0;
        cur_sw = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", led, 0);
        check("rst_irq", irq, 0);
        check("rst_fault", bus_fault, 0);
        check("rst_tcount", readdata, 0);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // RAM write then same-cycle read
        adr = 32'h10; writedata = 32'hCAFE_0001; MemWrite = 1; #1;
        check("ram_we_10", ram_we, 1);
        check("ram_adr_10", 32'(ram_adr), 4);
        step(32'h10, 32'hCAFE_0001, 1, 0, 0);
        step(32'h10, 0, 0, 0, 32'h1234);

        // LED and switch synchroniser
        step(32'hFFFF_FF00, 32'h0001_00A5, 1, 0, 0);
        check("led_a5", led, 16'h00A5);
        check("led_rd", readdata, 32'hA5);
        step(32'hFFFF_FF04, 0, 0, 16'h3C3C, 0);
        check("sw_edge1", readdata, 0);
        step(32'hFFFF_FF04, 0, 0, 16'h3C3C, 0);
        check("sw_edge2", readdata, 32'h3C3C);

        // one-shot timer: TLOAD=3, TCTRL=EN|IE
        step(32'hFFFF_FF0C, 3, 1, 16'h3C3C, 0);
        step(32'hFFFF_FF08, 5, 1, 16'h3C3C, 0);
        repeat (11) step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);
        check("tcnt_c11", readdata, 1);
        step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);
        check("tcnt_c12", readdata, 0);
        repeat (3) step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);
        check("irq_c15", irq, 0);
        step(32'hFFFF_FF08, 0, 0, 16'h3C3C, 0);
        check("irq_c16", irq, 1);
        check("en_cleared", readdata, 32'h4);
        step(32'hFFFF_FF14, 1, 1, 16'h3C3C, 0);
        check("irq_w1c", irq, 0);

        // auto-reload with a clear landing in the expiry cycle
        step(32'hFFFF_FF0C, 2, 1, 16'h3C3C, 0);
        step(32'hFFFF_FF08, 7, 1, 16'h3C3C, 0);
        repeat (11) step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);
        step(32'hFFFF_FF14, 1, 1, 16'h3C3C, 0);
        check("exp_set_wins", readdata, 1);
        adr = 32'hFFFF_FF10; MemWrite = 0; #1;
        check("auto_reload", readdata, 2);
        repeat (12) step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);

        // reset mid-count
        step(32'hFFFF_FF0C, 7, 1, 16'h3C3C, 0);
        step(32'hFFFF_FF10, 0, 0, 16'h3C3C, 0);
        check("pre_rst_tcnt", readdata, 7);
        check("pre_rst_irq", irq, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_led", led, 0);
        check("arst_irq", irq, 0);
        check("arst_fault", bus_fault, 0);
        check("arst_tcount", readdata, 0);
        rst = 1'b1;
        model_reset();
        cur_sw = 0;
        repeat (10) step(32'hFFFF_FF10, 0, 0, 0, 0);
        check("post_rst_tcnt", readdata, 0);

        // unmapped accesses
        step(32'hFFFF_FF18, 0, 1, 0, 0);
        step(32'h8000_0000, 0, 0, 0, 32'hDEAD_BEEF);
        step(32'h9000_0000, 32'h55, 1, 0, 0);
`ifdef MMIO_BUS_FAULT_EN
        check("fault_set", bus_fault, 1);
        adr = 32'hFFFF_FF18; MemWrite = 0; #1;
        check("fault_adr", readdata, 32'h8000_0000);
        step(32'hFFFF_FF18, 32'h1234, 1, 0, 0);
        check("fault_clr", bus_fault, 0);
        check("fault_adr_clr", readdata, 0);
`else
        check("fault_tied", bus_fault, 0);
        adr = 32'hFFFF_FF18; MemWrite = 0; #1;
        check("fault_ofs_rsvd", readdata, 0);
`endif

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, d;
            logic [7:0]  o;
            logic        w;
            int          k;
            k = $urandom_range(0, 9);
            w = ($urandom_range(0, 9) < 4);
            d = $urandom;
            if ($urandom_range(0, 15) == 0) cur_sw = 16'($urandom);
            if (k < 2) begin
                a = $urandom_range(0, RAM_BYTES - 1);
            end else if (k < 7) begin
                o = offs[$urandom_range(0, 9)];
                a = {24'hFFFFFF, o | 8'($urandom_range(0, 3))};
                if (o == 8'h08) d = $urandom_range(0, 7);
                if (o == 8'h0C) d = $urandom_range(0, 6);
            end else if (k == 7) begin
                a = $urandom_range(32'h7FFF_FFFF, RAM_BYTES);
            end else begin
                a = 32'hFFFF_FF10;
                w = 1'b0;
            end
            step(a, d, w, cur_sw, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
